// File: rtl/mask_serializer.sv
// rtl/mask_serializer.sv - serializes a bit mask into ascending set-bit indices, one per handshake.
// Optional MASK_SERIALIZER_COUNT_EN adds out_count (popcount of the captured mask).
module mask_serializer #(
  parameter int MASK_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MASK_W-1:0] in_mask,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done
`ifdef MASK_SERIALIZER_COUNT_EN
  ,
  output logic [IDX_W:0]    out_count
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  state_t            state, state_nxt;
  logic [MASK_W-1:0] shadow;
  logic [IDX_W-1:0]  low_idx;
  logic              single;
  logic              capture;

  assign capture = (state == IDLE) && in_valid;

  // Descending scan so the last hit wins, leaving the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (shadow[i]) low_idx = IDX_W'(i);
    end
  end

  assign single = (shadow != '0) && ((shadow & (shadow - MASK_W'(1))) == '0);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_mask != '0) ? SCAN : FINISH;
      end
      SCAN: begin
        out_valid = 1'b1;
        out_idx   = low_idx;
        out_last  = single;
        if (out_ready && single) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        shadow <= in_mask;
      end else if (state == SCAN && out_ready) begin
        shadow <= shadow & (shadow - MASK_W'(1));
      end
    end
  end

`ifdef MASK_SERIALIZER_COUNT_EN
  function automatic logic [IDX_W:0] popcount(input logic [MASK_W-1:0] m);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < MASK_W; i++) c = c + (IDX_W + 1)'(m[i]);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (capture) begin
      out_count <= popcount(in_mask);
    end
  end
`endif

endmodule

// File: tb/tb_mask_serializer.sv
// tb/tb_mask_serializer.sv - self-checking bench for mask_serializer (vector table, directed and random masks).
module tb_mask_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_mask;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        done;
`ifdef MASK_SERIALIZER_COUNT_EN
  logic [5:0]  out_count;
`endif

  int compared = 0;
  int failed   = 0;

  mask_serializer #(.MASK_W(32), .IDX_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_mask  (in_mask),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_idx  (out_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .done     (done)
`ifdef MASK_SERIALIZER_COUNT_EN
    ,
    .out_count(out_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mask;
    int          mode;    // 0: ready held, 1: toggle starting low, 2: random
    bit          inject;  // drive a second mask during the scan
    int          exp_n;
    int          exp_last;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_out_last"}, 32'(out_last), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_out_idx"}, 32'(out_idx), 32'd0);
  endtask

  // Reference: expected indices come from walking the mask bits upward.
  task automatic run_mask(input logic [31:0] m, input int mode, input bit inject,
                          output int n_emit, output int last_idx);
    int q[$];
    int cyc;
    bit tog;
    for (int i = 0; i < 32; i++) if (m[i]) q.push_back(i);
    n_emit   = 0;
    last_idx = -1;
    check("cap_in_ready", 32'(in_ready), 32'd1);
    in_mask  = m;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_mask  = '0;
`ifdef MASK_SERIALIZER_COUNT_EN
    check("out_count", 32'(out_count), 32'(q.size()));
`endif
    tog = 1'b0;
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = tog;
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
      tog = !tog;
      if (inject) begin
        in_valid = 1'b1;
        in_mask  = 32'hFFFF_FFFF;
      end
      check("scan_out_valid", 32'(out_valid), 32'd1);
      check("scan_out_idx", 32'(out_idx), 32'(q[0]));
      check("scan_out_last", 32'(out_last), 32'(q.size() == 1));
      check("scan_done", 32'(done), 32'd0);
      check("scan_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        n_emit++;
        if (out_last) last_idx = int'(out_idx);
      end
      if (out_ready) void'(q.pop_front());
      cyc++;
      @(negedge clk);
    end
    if (q.size() > 0) check("scan_timeout", 32'(q.size()), 32'd0);
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b0;
    check("fin_done", 32'(done), 32'd1);
    check("fin_out_valid", 32'(out_valid), 32'd0);
    check("fin_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_idle("post");
  endtask

  vec_t vecs[8];
  int   n_emit, last_idx, exp_last;
  logic [31:0] rm;

  initial begin
    vecs[0] = '{32'h000F_FFF0, 0, 1'b0, 16, 19};
    vecs[1] = '{32'h0000_0000, 0, 1'b0,  0, -1};
    vecs[2] = '{32'h8000_0001, 1, 1'b0,  2, 31};
    vecs[3] = '{32'h0000_0550, 0, 1'b1,  4, 10};
    vecs[4] = '{32'hFFFF_FFFF, 2, 1'b0, 32, 31};
    vecs[5] = '{32'h8000_0000, 1, 1'b0,  1, 31};
    vecs[6] = '{32'h0000_0001, 2, 1'b1,  1,  0};
    vecs[7] = '{32'h0000_0002, 0, 1'b0,  1,  1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle");

    foreach (vecs[k]) begin
      run_mask(vecs[k].mask, vecs[k].mode, vecs[k].inject, n_emit, last_idx);
      check($sformatf("vec%0d_count", k), 32'(n_emit), 32'(vecs[k].exp_n));
      check($sformatf("vec%0d_last", k), 32'(last_idx), 32'(vecs[k].exp_last));
    end

    // Reset after three accepted indices aborts the mask; rst beats in_valid.
    in_mask  = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("abort_idx", 32'(out_idx), 32'(i));
      @(negedge clk);
    end
    rst      = 1'b1;
    in_valid = 1'b1;
    in_mask  = 32'h0000_0004;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_mask  = '0;
    check_idle("abort");
    @(negedge clk);
    check_idle("abort_nodone");
    out_ready = 1'b0;
    run_mask(32'h0000_0002, 0, 1'b0, n_emit, last_idx);
    check("abort_next_count", 32'(n_emit), 32'd1);
    check("abort_next_last", 32'(last_idx), 32'd1);

    for (int r = 0; r < 16; r++) begin
      rm = (r % 5 == 4) ? 32'h0 : ($urandom() & $urandom());
      exp_last = -1;
      for (int i = 0; i < 32; i++) if (rm[i]) exp_last = i;
      run_mask(rm, 2, 1'(r % 2), n_emit, last_idx);
      check("rand_count", 32'(n_emit), 32'($countones(rm)));
      check("rand_last", 32'(last_idx), 32'(exp_last));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
